// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for a MIPS-subset datapath
//   (ADD/SUB/AND/OR/SLT, ADDI/LW/SW/SLTI/BEQ). It steps through
//   FETCH/DECODE/EXEC/MEM/WB and drives the datapath's write strobes and mux
//   selects. Instruction fetch and data access share a single memory port
//   through a req/ack handshake. The block counts retired instructions and
//   halts on an illegal opcode or when a memory access times out.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   run_i                   execute enable, sampled at instruction boundaries
//   op_i, funct_i           instr[31:26] / instr[5:0] from the instruction reg
//   zero_i                  ALU result == 0 (used for BEQ in EXEC)
//   mem_ack_i               memory completes the current access this cycle
//   mem_read_o/mem_write_o  memory requests, held until ack
//   i_or_d_o                memory address: 0 = PC, 1 = ALUOut
//   ir_write_o, pc_write_o  instruction-register / PC load strobes
//   pc_src_o                PC input: 0 = ALU result, 1 = ALUOut
//   alu_src_a_o/_b_o        ALU operand selects
//   alu_op_o                0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
//   reg_write_o, reg_dst_o, mem_to_reg_o   register-file write controls
//   state_o                 0 IDLE .. 6 HALT
//   illegal_o, timeout_o    sticky error flags
//   instr_cnt_o             retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,   // 1..255
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [5:0]       op_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ack_i,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             i_or_d_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [2:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // Last wait-count value at which an ack is still accepted.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [5:0]       op_q;
    logic [5:0]       funct_q;
    logic [7:0]       wait_cnt;
    logic             illegal_q;
    logic             timeout_q;
    logic [CNT_W-1:0] instr_cnt_q;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                             (fn == FN_OR)  || (fn == FN_SLT);
            OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    logic wait_expired;
    logic retire;
    logic in_access;

    assign in_access    = (state == S_FETCH) || (state == S_MEM);
    assign wait_expired = (wait_cnt == WAIT_LAST) && !mem_ack_i;
    assign retire       = ((state == S_EXEC) && (op_q == OP_BEQ)) ||
                          ((state == S_MEM)  && (op_q == OP_SW) && mem_ack_i) ||
                          (state == S_WB);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; it is only seen on a rising clock edge.
        if (rst_i) begin
            state       <= S_IDLE;
            op_q        <= '0;
            funct_q     <= '0;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (run_i) state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ack_i) begin
                        state <= S_DECODE;
                    end else if (wait_expired) begin
                        state     <= S_HALT;
                        timeout_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q    <= op_i;
                    funct_q <= funct_i;
                    if (is_legal(op_i, funct_i)) begin
                        state <= S_EXEC;
                    end else begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW: state <= S_MEM;
                        OP_BEQ:       state <= run_i ? S_FETCH : S_IDLE;
                        default:      state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack_i) begin
                        if (op_q == OP_LW) state <= S_WB;
                        else               state <= run_i ? S_FETCH : S_IDLE;
                    end else if (wait_expired) begin
                        state     <= S_HALT;
                        timeout_q <= 1'b1;
                    end
                end
                S_WB:    state <= run_i ? S_FETCH : S_IDLE;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase

            // Counts unacknowledged cycles of the current access; any other
            // state or an ack clears it, so each FETCH/MEM entry starts at 0.
            if (in_access && !mem_ack_i) wait_cnt <= wait_cnt + 8'd1;
            else                         wait_cnt <= '0;

            if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every output gets a default before the case so no latch is
    // inferred for states that leave a signal unassigned.
    always_comb begin
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        alu_op_o     = ALU_ADD;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        state_o      = 3'd0;
        illegal_o    = 1'b0;
        timeout_o    = 1'b0;
        instr_cnt_o  = '0;
        // Everything is forced low while reset is asserted, which also drops
        // any in-flight memory request immediately.
        if (!rst_i) begin
            state_o     = state;
            illegal_o   = illegal_q;
            timeout_o   = timeout_q;
            instr_cnt_o = instr_cnt_q;
            case (state)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'd1;
                    ir_write_o  = mem_ack_i;
                    pc_write_o  = mem_ack_i;
                end
                S_DECODE: alu_src_b_o = 2'd3;   // precompute branch target
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    case (op_q)
                        OP_RTYPE: alu_op_o = r_alu_op(funct_q);
                        OP_ADDI, OP_LW, OP_SW: alu_src_b_o = 2'd2;
                        OP_SLTI: begin
                            alu_src_b_o = 2'd2;
                            alu_op_o    = ALU_SLT;
                        end
                        OP_BEQ: begin
                            alu_op_o   = ALU_SUB;
                            pc_write_o = zero_i;
                            pc_src_o   = zero_i;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d_o    = 1'b1;
                    mem_read_o  = (op_q == OP_LW);
                    mem_write_o = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (op_q == OP_RTYPE);
                    mem_to_reg_o = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl (MEM_TIMEOUT=4, CNT_W=2). The driver
//   applies one cycle of inputs and queues the hand-computed outputs for that
//   cycle; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_i, run_i, zero_i, mem_ack_i;
    logic [5:0] op_i, funct_i;
    logic       mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o;
    logic       alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o, illegal_o, timeout_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o, state_o;
    logic [1:0] instr_cnt_o;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .run_i        (run_i),
        .op_i         (op_i),
        .funct_i      (funct_i),
        .zero_i       (zero_i),
        .mem_ack_i    (mem_ack_i),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .i_or_d_o     (i_or_d_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .state_o      (state_o),
        .illegal_o    (illegal_o),
        .timeout_o    (timeout_o),
        .instr_cnt_o  (instr_cnt_o)
    );

    // ctl bits: {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
    //            alu_src_a, alu_src_b[1:0], alu_op[2:0], reg_write, reg_dst, mem_to_reg}
    localparam logic [14:0] C_NONE    = 15'b000_000_0_00_000_000;
    localparam logic [14:0] C_FETCH_W = 15'b100_000_0_01_000_000;
    localparam logic [14:0] C_FETCH_A = 15'b100_110_0_01_000_000;
    localparam logic [14:0] C_DEC     = 15'b000_000_0_11_000_000;
    localparam logic [14:0] C_EX_ADD  = 15'b000_000_1_00_000_000;
    localparam logic [14:0] C_EX_SUB  = 15'b000_000_1_00_001_000;
    localparam logic [14:0] C_EX_IMM  = 15'b000_000_1_10_000_000;
    localparam logic [14:0] C_EX_SLTI = 15'b000_000_1_10_100_000;
    localparam logic [14:0] C_BEQ_T   = 15'b000_011_1_00_001_000;
    localparam logic [14:0] C_BEQ_N   = 15'b000_000_1_00_001_000;
    localparam logic [14:0] C_MEM_LW  = 15'b101_000_0_00_000_000;
    localparam logic [14:0] C_MEM_SW  = 15'b011_000_0_00_000_000;
    localparam logic [14:0] C_WB_R    = 15'b000_000_0_00_000_110;
    localparam logic [14:0] C_WB_I    = 15'b000_000_0_00_000_100;
    localparam logic [14:0] C_WB_LW   = 15'b000_000_0_00_000_101;

    typedef struct packed {
        logic [14:0] ctl;
        logic [2:0]  st;
        logic        ill;
        logic        to;
        logic [1:0]  cnt;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // One clock of stimulus plus the outputs expected during that clock.
    task automatic cyc(input string nm, input logic rst, input logic run,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, input logic ack,
                       input logic [14:0] ctl, input logic [2:0] st,
                       input logic ill, input logic to, input logic [1:0] cnt);
        item_t it;
        @(posedge clk_i);
        #1;
        rst_i     = rst;
        run_i     = run;
        op_i      = op;
        funct_i   = fn;
        zero_i    = zero;
        mem_ack_i = ack;
        it.name   = nm;
        it.exp    = '{ctl: ctl, st: st, ill: ill, to: to, cnt: cnt};
        sb.push_back(it);
    endtask

    // Monitor: compares the DUT's outputs mid-cycle against the queued entry.
    item_t cur;
    obs_t  act;
    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            act = '{ctl: {mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
                          pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                          reg_write_o, reg_dst_o, mem_to_reg_o},
                    st: state_o, ill: illegal_o, to: timeout_o, cnt: instr_cnt_o};
            n_checks++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b st=%0d ill=%b to=%b cnt=%0d, expected ctl=%b st=%0d ill=%b to=%b cnt=%0d",
                         cur.name, act.ctl, act.st, act.ill, act.to, act.cnt,
                         cur.exp.ctl, cur.exp.st, cur.exp.ill, cur.exp.to, cur.exp.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; run_i = 1'b0; op_i = '0; funct_i = '0; zero_i = 1'b0; mem_ack_i = 1'b0;
        //   name          rst run op     fn     z  ack ctl        st ill to cnt
        cyc("reset",       1, 0, 6'h00, 6'h00, 0, 0, C_NONE,    0, 0, 0, 0);
        cyc("idle_hold",   0, 0, 6'h00, 6'h00, 0, 0, C_NONE,    0, 0, 0, 0);
        cyc("idle_run",    0, 1, 6'h00, 6'h20, 0, 0, C_NONE,    0, 0, 0, 0);
        // ADD with ack in the fetch cycle: states 1,2,3,5
        cyc("add_fetch",   0, 1, 6'h00, 6'h20, 0, 1, C_FETCH_A, 1, 0, 0, 0);
        cyc("add_decode",  0, 1, 6'h00, 6'h20, 0, 0, C_DEC,     2, 0, 0, 0);
        cyc("add_exec",    0, 1, 6'h00, 6'h20, 0, 0, C_EX_ADD,  3, 0, 0, 0);
        cyc("add_wb",      0, 1, 6'h00, 6'h20, 0, 0, C_WB_R,    5, 0, 0, 0);
        // LW: one fetch wait, three-cycle ack in MEM, then WB; run_i drops in WB
        cyc("lw_fetch_w",  0, 1, 6'h23, 6'h00, 0, 0, C_FETCH_W, 1, 0, 0, 1);
        cyc("lw_fetch_a",  0, 1, 6'h23, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 1);
        cyc("lw_decode",   0, 1, 6'h23, 6'h00, 0, 0, C_DEC,     2, 0, 0, 1);
        cyc("lw_exec",     0, 1, 6'h23, 6'h00, 0, 0, C_EX_IMM,  3, 0, 0, 1);
        cyc("lw_mem1",     0, 1, 6'h23, 6'h00, 0, 0, C_MEM_LW,  4, 0, 0, 1);
        cyc("lw_mem2",     0, 1, 6'h23, 6'h00, 0, 0, C_MEM_LW,  4, 0, 0, 1);
        cyc("lw_mem3_ack", 0, 1, 6'h23, 6'h00, 0, 1, C_MEM_LW,  4, 0, 0, 1);
        cyc("lw_wb",       0, 0, 6'h23, 6'h00, 0, 0, C_WB_LW,   5, 0, 0, 1);
        cyc("boundary_idle",0,0, 6'h23, 6'h00, 0, 0, C_NONE,    0, 0, 0, 2);
        cyc("idle_run2",   0, 1, 6'h2B, 6'h00, 0, 0, C_NONE,    0, 0, 0, 2);
        // SW: ack in the 4th (last allowed) MEM cycle; run_i dropped mid-instruction
        cyc("sw_fetch",    0, 1, 6'h2B, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 2);
        cyc("sw_decode",   0, 1, 6'h2B, 6'h00, 0, 0, C_DEC,     2, 0, 0, 2);
        cyc("sw_exec",     0, 0, 6'h2B, 6'h00, 0, 0, C_EX_IMM,  3, 0, 0, 2);
        cyc("sw_mem1",     0, 0, 6'h2B, 6'h00, 0, 0, C_MEM_SW,  4, 0, 0, 2);
        cyc("sw_mem2",     0, 0, 6'h2B, 6'h00, 0, 0, C_MEM_SW,  4, 0, 0, 2);
        cyc("sw_mem3",     0, 0, 6'h2B, 6'h00, 0, 0, C_MEM_SW,  4, 0, 0, 2);
        cyc("sw_mem4_ack", 0, 1, 6'h2B, 6'h00, 0, 1, C_MEM_SW,  4, 0, 0, 2);
        // BEQ taken, then not taken; counter wraps 3 -> 0 -> 1
        cyc("beqt_fetch",  0, 1, 6'h04, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 3);
        cyc("beqt_decode", 0, 1, 6'h04, 6'h00, 0, 0, C_DEC,     2, 0, 0, 3);
        cyc("beqt_exec",   0, 1, 6'h04, 6'h00, 1, 0, C_BEQ_T,   3, 0, 0, 3);
        cyc("beqn_fetch",  0, 1, 6'h04, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 0);
        cyc("beqn_decode", 0, 1, 6'h04, 6'h00, 0, 0, C_DEC,     2, 0, 0, 0);
        cyc("beqn_exec",   0, 1, 6'h04, 6'h00, 0, 0, C_BEQ_N,   3, 0, 0, 0);
        // SLTI
        cyc("slti_fetch",  0, 1, 6'h0A, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 1);
        cyc("slti_decode", 0, 1, 6'h0A, 6'h00, 0, 0, C_DEC,     2, 0, 0, 1);
        cyc("slti_exec",   0, 1, 6'h0A, 6'h00, 0, 0, C_EX_SLTI, 3, 0, 0, 1);
        cyc("slti_wb",     0, 1, 6'h0A, 6'h00, 0, 0, C_WB_I,    5, 0, 0, 1);
        // R-type SUB
        cyc("sub_fetch",   0, 1, 6'h00, 6'h22, 0, 1, C_FETCH_A, 1, 0, 0, 2);
        cyc("sub_decode",  0, 1, 6'h00, 6'h22, 0, 0, C_DEC,     2, 0, 0, 2);
        cyc("sub_exec",    0, 1, 6'h00, 6'h22, 0, 0, C_EX_SUB,  3, 0, 0, 2);
        cyc("sub_wb",      0, 1, 6'h00, 6'h22, 0, 0, C_WB_R,    5, 0, 0, 2);
        // Illegal opcode: HALT, count unchanged, run_i/mem_ack_i ignored
        cyc("ill_fetch",   0, 1, 6'h3F, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 3);
        cyc("ill_decode",  0, 1, 6'h3F, 6'h00, 0, 0, C_DEC,     2, 0, 0, 3);
        cyc("ill_halt1",   0, 0, 6'h3F, 6'h00, 0, 1, C_NONE,    6, 1, 0, 3);
        cyc("ill_halt2",   0, 1, 6'h3F, 6'h00, 0, 1, C_NONE,    6, 1, 0, 3);
        cyc("ill_halt3",   0, 0, 6'h3F, 6'h00, 0, 0, C_NONE,    6, 1, 0, 3);
        // Reset out of HALT, then reset in the MEM state of an SW
        cyc("rst_halt",    1, 0, 6'h2B, 6'h00, 0, 0, C_NONE,    0, 0, 0, 0);
        cyc("rst_idle",    0, 1, 6'h2B, 6'h00, 0, 0, C_NONE,    0, 0, 0, 0);
        cyc("sw2_fetch",   0, 1, 6'h2B, 6'h00, 0, 1, C_FETCH_A, 1, 0, 0, 0);
        cyc("sw2_decode",  0, 1, 6'h2B, 6'h00, 0, 0, C_DEC,     2, 0, 0, 0);
        cyc("sw2_exec",    0, 1, 6'h2B, 6'h00, 0, 0, C_EX_IMM,  3, 0, 0, 0);
        cyc("sw2_mem",     0, 1, 6'h2B, 6'h00, 0, 0, C_MEM_SW,  4, 0, 0, 0);
        cyc("sw2_rst",     1, 1, 6'h2B, 6'h00, 0, 0, C_NONE,    0, 0, 0, 0);
        cyc("sw2_after",   0, 0, 6'h2B, 6'h00, 0, 0, C_NONE,    0, 0, 0, 0);
        // Fetch timeout: four cycles without ack, then HALT
        cyc("to_idle",     0, 1, 6'h00, 6'h20, 0, 0, C_NONE,    0, 0, 0, 0);
        cyc("to_fetch1",   0, 1, 6'h00, 6'h20, 0, 0, C_FETCH_W, 1, 0, 0, 0);
        cyc("to_fetch2",   0, 1, 6'h00, 6'h20, 0, 0, C_FETCH_W, 1, 0, 0, 0);
        cyc("to_fetch3",   0, 1, 6'h00, 6'h20, 0, 0, C_FETCH_W, 1, 0, 0, 0);
        cyc("to_fetch4",   0, 1, 6'h00, 6'h20, 0, 0, C_FETCH_W, 1, 0, 0, 0);
        cyc("to_halt1",    0, 1, 6'h00, 6'h20, 0, 1, C_NONE,    6, 0, 1, 0);
        cyc("to_halt2",    0, 1, 6'h00, 6'h20, 0, 1, C_NONE,    6, 0, 1, 0);

        @(negedge clk_i);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
